// File: rtl/tmr_pkg.sv
// Shared constants for the triplicated decoder: lane indices and default counter width.
package tmr_pkg;
  localparam int LANE_A        = 0;
  localparam int LANE_B        = 1;
  localparam int LANE_C        = 2;
  localparam int NUM_LANES     = 3;
  localparam int CNT_W_DEFAULT = 8;
endpackage

// File: rtl/majority_voter_err.sv
// 2-of-3 majority voter that also reports which replicas disagree with the vote.
module majority_voter_err
  import tmr_pkg::*;
(
  input  logic [2:0] i_rep,
  output logic       o_vote,
  output logic [2:0] o_mis
);
  assign o_vote = (i_rep[LANE_A] & i_rep[LANE_B]) |
                  (i_rep[LANE_A] & i_rep[LANE_C]) |
                  (i_rep[LANE_B] & i_rep[LANE_C]);
  assign o_mis  = i_rep ^ {3{o_vote}};
endmodule

// File: rtl/tmr_diff_decoder.sv
// Differential (XOR) decoder with a triplicated, voted and scrubbed previous-bit register.
// Optional per-lane saturating mismatch counters under TMR_DEC_ERR_CNT_EN.
module tmr_diff_decoder
  import tmr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in,
  input  logic [2:0] inj,
  input  logic       err_clr,
  output logic       out_valid,
  output logic       out,
  output logic       err,
  output logic [2:0] err_lane
`ifdef TMR_DEC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
`endif
);
  logic [2:0] w_rep;
  logic [2:0] w_mis;
  logic [2:0] w_flag;
  logic [2:0] w_rep_next;
  logic       w_prev;
  logic       r_out;
  logic       r_out_valid;
  logic       r_err;

  majority_voter_err u_voter (
    .i_rep  (w_rep),
    .o_vote (w_prev),
    .o_mis  (w_mis)
  );

  // Idle cycles reload every replica from the vote, which scrubs a single upset.
  always_comb begin
    w_rep_next = (in_valid ? {3{in}} : {3{w_prev}}) ^ inj;
  end

`ifdef TMR_DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] w_cnt [NUM_LANES];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
      logic r_rep;
      logic r_flag;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_rep  <= 1'b0;
          r_flag <= 1'b0;
        end else begin
          r_rep <= w_rep_next[gi];
          if (w_mis[gi]) begin
            r_flag <= 1'b1;
          end else if (err_clr) begin
            r_flag <= 1'b0;
          end
        end
      end

      assign w_rep[gi]  = r_rep;
      assign w_flag[gi] = r_flag;

`ifdef TMR_DEC_ERR_CNT_EN
      logic [CNT_W-1:0] r_cnt;

      // A mismatch coinciding with a clear restarts the count at one.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (w_mis[gi]) begin
          if (err_clr) begin
            r_cnt <= CNT_W'(1);
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end else if (err_clr) begin
          r_cnt <= '0;
        end
      end

      assign w_cnt[gi] = r_cnt;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= in ^ w_prev;
      end
      if (|w_mis) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign err       = r_err;
  assign err_lane  = w_flag;

`ifdef TMR_DEC_ERR_CNT_EN
  assign cnt_a = w_cnt[LANE_A];
  assign cnt_b = w_cnt[LANE_B];
  assign cnt_c = w_cnt[LANE_C];
`endif
endmodule

// File: tb/tb_tmr_diff_decoder.sv
// Table-driven bench for tmr_diff_decoder (CNT_W=2), with hand sequences for reset and double fault.
module tb_tmr_diff_decoder;
  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       din;
  logic [2:0] inj;
  logic       err_clr;
  logic       out_valid;
  logic       dout;
  logic       err;
  logic [2:0] err_lane;
`ifdef TMR_DEC_ERR_CNT_EN
  logic [CW-1:0] cnt_a, cnt_b, cnt_c;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tmr_diff_decoder #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (din),
    .inj       (inj),
    .err_clr   (err_clr),
    .out_valid (out_valid),
    .out       (dout),
    .err       (err),
    .err_lane  (err_lane)
`ifdef TMR_DEC_ERR_CNT_EN
    ,
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c)
`endif
  );

  typedef struct {
    logic       vld;
    logic       d;
    logic [2:0] inj;
    logic       clr;
    logic       e_ov;
    logic       e_out;
    logic       e_err;
    logic [2:0] e_lane;
    int         e_ca;
    int         e_cb;
    int         e_cc;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic d, input logic [2:0] j, input logic c);
    rst = r; in_valid = v; din = d; inj = j; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic ov, input logic o, input logic e, input logic [2:0] l,
                          input int ca, input int cb, input int cc);
    chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
    chk({tag, ".out"}, int'(dout), int'(o));
    chk({tag, ".err"}, int'(err), int'(e));
    chk({tag, ".err_lane"}, int'(err_lane), int'(l));
`ifdef TMR_DEC_ERR_CNT_EN
    chk({tag, ".cnt_a"}, int'(cnt_a), ca);
    chk({tag, ".cnt_b"}, int'(cnt_b), cb);
    chk({tag, ".cnt_c"}, int'(cnt_c), cc);
`else
    if (ca + cb + cc < 0) $display("unreachable");
`endif
  endtask

  initial begin
    // vld d inj clr | ov out err lane ca cb cc
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[4]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[6]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 0, 1, 0};
    vecs[7]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 0, 1, 0};
    vecs[8]  = '{1'b1, 1'b1, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1, 0, 0};
    vecs[10] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b001, 1, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1, 0, 1};
    vecs[12] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1, 0, 2};
    vecs[13] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1, 0, 3};
    vecs[14] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1, 0, 3};
    vecs[15] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1, 0, 3};
    vecs[16] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[17] = '{1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 0, 0, 0};
    vecs[18] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 0, 0, 1};
    vecs[19] = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 0, 0, 1};

    rst = 1'b1; in_valid = 1'b0; din = 1'b0; inj = 3'b000; err_clr = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
    chk("reset.rep", int'(dut.w_rep), 0);

    for (int i = 0; i < 20; i++) begin
      drive(1'b0, vecs[i].vld, vecs[i].d, vecs[i].inj, vecs[i].clr);
      $display("vec %0d: vld=%0b in=%0b inj=%03b clr=%0b -> ov=%0b out=%0b err=%0b lane=%03b",
               i, vecs[i].vld, vecs[i].d, vecs[i].inj, vecs[i].clr, out_valid, dout, err, err_lane);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_out, vecs[i].e_err, vecs[i].e_lane,
               vecs[i].e_ca, vecs[i].e_cb, vecs[i].e_cc);
      if (i == 6) chk("scrub.rep", int'(dut.w_rep), 7);
    end

    // Reset wins over in_valid, inj and err_clr in the same cycle.
    drive(1'b1, 1'b1, 1'b0, 3'b111, 1'b1);
    $display("rst_mid: ov=%0b out=%0b err=%0b lane=%03b", out_valid, dout, err, err_lane);
    chk_outs("rst_mid", 1'b0, 1'b0, 1'b0, 3'b000, 0, 0, 0);
    chk("rst_mid.rep", int'(dut.w_rep), 0);
    drive(1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    $display("post_rst: ov=%0b out=%0b", out_valid, dout);
    chk_outs("post_rst", 1'b1, 1'b1, 1'b0, 3'b000, 0, 0, 0);

    // Double fault: lanes A and B flipped, vote wrong, lane C flagged.
    drive(1'b0, 1'b0, 1'b0, 3'b011, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 3'b000, 1'b0);
    $display("dbl_fault: ov=%0b out=%0b err=%0b lane=%03b", out_valid, dout, err, err_lane);
    chk_outs("dbl_fault", 1'b1, 1'b1, 1'b1, 3'b100, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
